// File: rtl/eeprom_access_arbiter.sv
// Round-robin arbiter sharing one serial-EEPROM read/write engine between requesters A and B.
// Latches one request, drives the engine, waits for ACK, covers write recovery, reports done/err.
module eeprom_access_arbiter #(
    parameter logic [15:0] WR_WAIT_CYC = 16'd10000,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
    parameter int unsigned ADDR_W      = 11
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic              a_done,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_done,
    output logic              b_err,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              eep_wr,
    output logic              eep_rd,
    output logic [ADDR_W-1:0] eep_addr,
    output logic [7:0]        eep_wdata,
    output logic              eep_data_oe,
    input  logic [7:0]        eep_rdata,
    input  logic              eep_ack
);

    typedef enum logic [4:0] {
        StIdle      = 5'b00001,
        StIssue     = 5'b00010,
        StWaitAck   = 5'b00100,
        StWrRecover = 5'b01000,
        StDone      = 5'b10000
    } state_e;

    state_e            state_q, state_d;
    logic              grant_b_q, grant_b_d;  // current grantee, doubles as last_grant
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [15:0]       tcnt_q, tcnt_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              oe_q, oe_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
    logic [7:0]        ewdata_q, ewdata_d;
    logic              tmo_hit;
    logic              rec_end;

    // 17-bit compares so a zero parameter cannot underflow.
    assign tmo_hit = ({1'b0, tcnt_q} + 17'd1) >= {1'b0, TIMEOUT_CYC};
    assign rec_end = ({1'b0, wcnt_q} + 17'd1) >= {1'b0, WR_WAIT_CYC};

    always_comb begin
        state_d   = state_q;
        grant_b_d = grant_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tcnt_d    = tcnt_q;
        wcnt_d    = wcnt_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        oe_d      = oe_q;
        eaddr_d   = eaddr_q;
        ewdata_d  = ewdata_q;
        unique case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    grant_b_d = b_req && (!a_req || !grant_b_q);
                    we_d      = grant_b_d ? b_we    : a_we;
                    addr_d    = grant_b_d ? b_addr  : a_addr;
                    wdata_d   = grant_b_d ? b_wdata : a_wdata;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                eaddr_d  = addr_q;
                ewdata_d = wdata_q;
                oe_d     = we_q;
                wr_d     = we_q;
                rd_d     = !we_q;
                tcnt_d   = 16'd0;
                state_d  = StWaitAck;
            end
            StWaitAck: begin
                tcnt_d = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
                if (eep_ack) begin
                    wr_d   = 1'b0;
                    rd_d   = 1'b0;
                    oe_d   = 1'b0;
                    wcnt_d = 16'd0;
                    if (!we_q) begin
                        rdata_d = eep_rdata;
                    end
                    state_d = we_q ? StWrRecover : StDone;
                end else if (tmo_hit) begin
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    oe_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StWrRecover: begin
                wcnt_d = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
                if (rec_end) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            grant_b_q <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'd0;
            tcnt_q    <= 16'd0;
            wcnt_q    <= 16'd0;
            err_q     <= 1'b0;
            rdata_q   <= 8'd0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            oe_q      <= 1'b0;
            eaddr_q   <= '0;
            ewdata_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            grant_b_q <= grant_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tcnt_q    <= tcnt_d;
            wcnt_q    <= wcnt_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            oe_q      <= oe_d;
            eaddr_q   <= eaddr_d;
            ewdata_q  <= ewdata_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign a_done      = (state_q == StDone) && !grant_b_q;
    assign b_done      = (state_q == StDone) && grant_b_q;
    assign a_err       = a_done && err_q;
    assign b_err       = b_done && err_q;
    assign rdata       = rdata_q;
    assign eep_wr      = wr_q;
    assign eep_rd      = rd_q;
    assign eep_addr    = eaddr_q;
    assign eep_wdata   = ewdata_q;
    assign eep_data_oe = oe_q;

endmodule
